// File: rtl/ask_frame_receiver_pkg.sv
// Shared constants for the serial ASK frame receiver: default window and
// threshold settings, FSM state encoding and SECDED codeword bit positions.
package ask_frame_receiver_pkg;

   localparam int SAMPLES_PER_BIT_DEF = 128;
   localparam int THRESH_DEF          = 128;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_START  = 2'd1;
   localparam logic [1:0] ST_DATA   = 2'd2;
   localparam logic [1:0] ST_FINISH = 2'd3;

   typedef enum logic [1:0] {
      S_IDLE   = ST_IDLE,
      S_START  = ST_START,
      S_DATA   = ST_DATA,
      S_FINISH = ST_FINISH
   } state_e;

   // Codeword layout {parity, d3, d2, d1, p4, d0, p2, p1}
   localparam int CW_P1  = 0;
   localparam int CW_P2  = 1;
   localparam int CW_D0  = 2;
   localparam int CW_P4  = 3;
   localparam int CW_D1  = 4;
   localparam int CW_D2  = 5;
   localparam int CW_D3  = 6;
   localparam int CW_PAR = 7;

endpackage

// File: rtl/ask_frame_receiver_if.sv
// Sample input and decoded-frame output bundle of the ASK frame receiver.
interface ask_frame_receiver_if;
   logic [7:0] sample_in;
   logic       sample_valid;
   logic [3:0] data_o;
   logic [7:0] codeword_o;
   logic       error1bit;
   logic       error2bit;
   logic       errorparity;
   logic       frame_valid;
   logic       frame_err;
   logic       busy;

   modport master (
      output sample_in, sample_valid,
      input  data_o, codeword_o, error1bit, error2bit, errorparity,
             frame_valid, frame_err, busy
   );

   modport slave (
      input  sample_in, sample_valid,
      output data_o, codeword_o, error1bit, error2bit, errorparity,
             frame_valid, frame_err, busy
   );
endinterface

// File: rtl/ask_frame_receiver_hamming74dec.sv
// Combinational Hamming(7,4) plus overall-parity decoder for one 8-bit frame.
module hamming74dec
   import ask_frame_receiver_pkg::*;
(
   input  logic [7:0] frame_i,
   output logic [3:0] data_o,
   output logic       error1bit_o,
   output logic       error2bit_o,
   output logic       errorparity_o
);

   logic [2:0] syn_s;
   logic [6:0] flip_s;
   logic [6:0] fixed_s;
   logic       overall_s;

   // Syndrome, single-bit correction and error classification
   always_comb begin
      syn_s[0] = frame_i[0] ^ frame_i[2] ^ frame_i[4] ^ frame_i[6];
      syn_s[1] = frame_i[1] ^ frame_i[2] ^ frame_i[5] ^ frame_i[6];
      syn_s[2] = frame_i[3] ^ frame_i[4] ^ frame_i[5] ^ frame_i[6];
      if (syn_s != 3'd0) begin
         flip_s = 7'd1 << (syn_s - 3'd1);
      end else begin
         flip_s = 7'd0;
      end
      fixed_s       = frame_i[6:0] ^ flip_s;
      overall_s     = ^frame_i;
      data_o        = {fixed_s[CW_D3], fixed_s[CW_D2], fixed_s[CW_D1], fixed_s[CW_D0]};
      error1bit_o   = (syn_s != 3'd0);
      error2bit_o   = (syn_s != 3'd0) & ~overall_s;
      errorparity_o = (syn_s == 3'd0) & overall_s;
   end

endmodule

// File: rtl/ask_frame_receiver.sv
// Serial ASK receiver: start-burst detect, per-bit threshold-count voting,
// LSB-first frame assembly and SECDED decode of the received byte.
module ask_frame_receiver
   import ask_frame_receiver_pkg::*;
#(
   parameter int SAMPLES_PER_BIT = SAMPLES_PER_BIT_DEF,
   parameter int THRESH          = THRESH_DEF,
   parameter int VOTE_MIN        = SAMPLES_PER_BIT / 4
) (
   input  logic                 clk,
   input  logic                 rst,
   ask_frame_receiver_if.slave  bus
);

   localparam int              CW       = $clog2(SAMPLES_PER_BIT + 1);
   localparam logic [CW-1:0]   LAST_IDX = CW'(SAMPLES_PER_BIT - 1);
   localparam logic [CW-1:0]   VOTE_L   = CW'(VOTE_MIN);
   localparam logic [7:0]      THRESH_L = 8'(THRESH);

   state_e          state_q, state_d;
   logic [CW-1:0]   sample_idx_q, sample_idx_d;
   logic [CW-1:0]   hi_cnt_q, hi_cnt_d;
   logic [2:0]      bit_idx_q, bit_idx_d;
   logic [7:0]      shreg_q, shreg_d;
   logic            frame_valid_d, frame_err_d;

   logic [3:0]      data_q;
   logic [7:0]      codeword_q;
   logic            err1_q, err2_q, errp_q;
   logic            frame_valid_q, frame_err_q, busy_q;

   logic            sample_hi_s, win_end_s, vote_s;
   logic [CW-1:0]   hi_final_s;
   logic [3:0]      dec_data_s;
   logic            dec_e1_s, dec_e2_s, dec_ep_s;

   assign sample_hi_s = bus.sample_in > THRESH_L;
   assign win_end_s   = (sample_idx_q == LAST_IDX);
   assign hi_final_s  = hi_cnt_q + {{(CW-1){1'b0}}, sample_hi_s};
   assign vote_s      = (hi_final_s > VOTE_L);

   // The decoder sees the next-state frame so its result is captured on the
   // same edge that enters FINISH, lining data up with the frame_valid pulse.
   hamming74dec u_dec (
      .frame_i       (shreg_d),
      .data_o        (dec_data_s),
      .error1bit_o   (dec_e1_s),
      .error2bit_o   (dec_e2_s),
      .errorparity_o (dec_ep_s)
   );

   // Next-state logic for the frame FSM, sample/bit counters and shift register
   always_comb begin
      state_d       = state_q;
      sample_idx_d  = sample_idx_q;
      hi_cnt_d      = hi_cnt_q;
      bit_idx_d     = bit_idx_q;
      shreg_d       = shreg_q;
      frame_valid_d = 1'b0;
      frame_err_d   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (bus.sample_valid && sample_hi_s) begin
               state_d      = S_START;
               sample_idx_d = CW'(1);
               hi_cnt_d     = CW'(1);
            end else begin
               state_d = S_IDLE;
            end
         end
         S_START, S_DATA: begin
            if (bus.sample_valid && win_end_s) begin
               sample_idx_d = '0;
               hi_cnt_d     = '0;
               if (state_q == S_START) begin
                  bit_idx_d   = 3'd0;
                  state_d     = vote_s ? S_DATA : S_IDLE;
                  frame_err_d = ~vote_s;
               end else begin
                  shreg_d[bit_idx_q] = vote_s;
                  if (bit_idx_q == 3'd7) begin
                     state_d       = S_FINISH;
                     frame_valid_d = 1'b1;
                  end else begin
                     bit_idx_d = bit_idx_q + 3'd1;
                  end
               end
            end else if (bus.sample_valid) begin
               sample_idx_d = sample_idx_q + CW'(1);
               hi_cnt_d     = hi_final_s;
            end else begin
               state_d = state_q;
            end
         end
         S_FINISH: begin
            state_d   = S_IDLE;
            bit_idx_d = 3'd0;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State, counters, shift register and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= S_IDLE;
         sample_idx_q  <= '0;
         hi_cnt_q      <= '0;
         bit_idx_q     <= 3'd0;
         shreg_q       <= 8'd0;
         data_q        <= 4'd0;
         codeword_q    <= 8'd0;
         err1_q        <= 1'b0;
         err2_q        <= 1'b0;
         errp_q        <= 1'b0;
         frame_valid_q <= 1'b0;
         frame_err_q   <= 1'b0;
         busy_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         sample_idx_q  <= sample_idx_d;
         hi_cnt_q      <= hi_cnt_d;
         bit_idx_q     <= bit_idx_d;
         shreg_q       <= shreg_d;
         frame_valid_q <= frame_valid_d;
         frame_err_q   <= frame_err_d;
         busy_q        <= (state_d != S_IDLE);
         if (frame_valid_d) begin
            data_q     <= dec_data_s;
            codeword_q <= shreg_d;
            err1_q     <= dec_e1_s;
            err2_q     <= dec_e2_s;
            errp_q     <= dec_ep_s;
         end
      end
   end

   assign bus.data_o      = data_q;
   assign bus.codeword_o  = codeword_q;
   assign bus.error1bit   = err1_q;
   assign bus.error2bit   = err2_q;
   assign bus.errorparity = errp_q;
   assign bus.frame_valid = frame_valid_q;
   assign bus.frame_err   = frame_err_q;
   assign bus.busy        = busy_q;

endmodule
